// File: rtl/div_share_ctrl.sv
// Two requesters share one sequential non-restoring divider (one quotient bit per clock).
// Round-robin grant, valid/ready on both request ports and on the id-tagged response port.
module div_share_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_dividend,
    input  logic [WIDTH-1:0] req0_divisor,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_dividend,
    input  logic [WIDTH-1:0] req1_divisor,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_quo,
    output logic [WIDTH-1:0] rsp_rem,
    output logic             rsp_dz,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic             id_q, id_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [CW-1:0]    step_q, step_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_quo_q, rsp_quo_d;
    logic [WIDTH-1:0] rsp_rem_q, rsp_rem_d;
    logic             rsp_dz_q, rsp_dz_d;

    logic             gnt0_s;
    logic             gnt1_s;
    logic             accept_s;
    logic             sel_id_s;
    logic [WIDTH-1:0] sel_dvd_s;
    logic [WIDTH-1:0] sel_dvs_s;
    logic             sel_dz_s;
    logic             rsp_fire_s;
    logic [WIDTH:0]   div_ext_s;
    logic [WIDTH:0]   acc_shift_s;
    logic [WIDTH:0]   acc_step_s;
    logic [WIDTH-1:0] quo_step_s;
    logic [WIDTH:0]   acc_fix_s;

    // Round-robin grant: ptr_q names the requester preferred when both are valid.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (state_q == S_IDLE) begin
            gnt0_s = req0_valid & (~req1_valid | ~ptr_q);
            gnt1_s = req1_valid & (~req0_valid |  ptr_q);
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    assign req0_ready = gnt0_s;
    assign req1_ready = gnt1_s;
    assign accept_s   = gnt0_s | gnt1_s;
    assign sel_id_s   = gnt1_s;
    assign sel_dvd_s  = gnt1_s ? req1_dividend : req0_dividend;
    assign sel_dvs_s  = gnt1_s ? req1_divisor  : req0_divisor;
    assign sel_dz_s   = (sel_dvs_s == {WIDTH{1'b0}});
    assign rsp_fire_s = rsp_valid_q & rsp_ready;

    // The extra accumulator bit lets intermediate sums wrap harmlessly for divisors >= 2^(WIDTH-1).
    assign div_ext_s   = {1'b0, div_q};
    assign acc_shift_s = {acc_q[WIDTH-1:0], quo_q[WIDTH-1]};
    assign acc_step_s  = acc_q[WIDTH] ? (acc_shift_s + div_ext_s) : (acc_shift_s - div_ext_s);
    assign quo_step_s  = {quo_q[WIDTH-2:0], ~acc_step_s[WIDTH]};
    assign acc_fix_s   = acc_q[WIDTH] ? (acc_q + div_ext_s) : acc_q;

    // Next-state and datapath update for the divider FSM.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        acc_d     = acc_q;
        quo_d     = quo_q;
        div_d     = div_q;
        step_d    = step_q;
        rsp_id_d  = rsp_id_q;
        rsp_quo_d = rsp_quo_q;
        rsp_rem_d = rsp_rem_q;
        rsp_dz_d  = rsp_dz_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    id_d   = sel_id_s;
                    ptr_d  = ~sel_id_s;
                    acc_d  = {(WIDTH + 1){1'b0}};
                    quo_d  = sel_dvd_s;
                    div_d  = sel_dvs_s;
                    step_d = {CW{1'b0}};
                    if (sel_dz_s) begin
                        state_d   = S_DONE;
                        rsp_id_d  = sel_id_s;
                        rsp_quo_d = {WIDTH{1'b1}};
                        rsp_rem_d = sel_dvd_s;
                        rsp_dz_d  = 1'b1;
                    end else begin
                        state_d = S_ITER;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ITER: begin
                acc_d  = acc_step_s;
                quo_d  = quo_step_s;
                step_d = step_q + {{(CW - 1){1'b0}}, 1'b1};
                if (step_q == LAST_STEP) begin
                    state_d = S_FIX;
                end else begin
                    state_d = S_ITER;
                end
            end
            S_FIX: begin
                acc_d     = acc_fix_s;
                state_d   = S_DONE;
                rsp_id_d  = id_q;
                rsp_quo_d = quo_q;
                rsp_rem_d = acc_fix_s[WIDTH-1:0];
                rsp_dz_d  = 1'b0;
            end
            S_DONE: begin
                if (rsp_fire_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Response valid rises one cycle after entering DONE and falls with the handshake.
    always_comb begin
        rsp_valid_d = 1'b0;
        if ((state_q == S_DONE) && !rsp_fire_s) begin
            rsp_valid_d = 1'b1;
        end else begin
            rsp_valid_d = 1'b0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= 1'b0;
            id_q        <= 1'b0;
            acc_q       <= {(WIDTH + 1){1'b0}};
            quo_q       <= {WIDTH{1'b0}};
            div_q       <= {WIDTH{1'b0}};
            step_q      <= {CW{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_quo_q   <= {WIDTH{1'b0}};
            rsp_rem_q   <= {WIDTH{1'b0}};
            rsp_dz_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            acc_q       <= acc_d;
            quo_q       <= quo_d;
            div_q       <= div_d;
            step_q      <= step_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_quo_q   <= rsp_quo_d;
            rsp_rem_q   <= rsp_rem_d;
            rsp_dz_q    <= rsp_dz_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_quo   = rsp_quo_q;
    assign rsp_rem   = rsp_rem_q;
    assign rsp_dz    = rsp_dz_q;
    assign busy      = (state_q != S_IDLE);

endmodule
